// File: rtl/serdes_tx_scheduler.sv
// Transmit scheduler for a 16:1 serializer lane: round-robin arbitration among
// word sources, IDLE fill, and periodic SYNC insertion aligned to the load slot.
module serdes_tx_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SYNC_INTERVAL = 8,
    parameter logic [15:0] IDLE_WORD     = 16'h00FF,
    parameter logic [15:0] SYNC_WORD     = 16'hF0F0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    lane_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    ser_enable,
    output logic [15:0]             ser_din,
    output logic                    busy,
    output logic [3:0]              slot_cnt,
    output logic [2:0]              cur_src,
    output logic                    cur_is_data
);

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned SLOT_W    = 4;
    localparam int unsigned SRC_W     = 3;
    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned SYNC_W    = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(15);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    logic                en_q;
    logic [WORD_W-1:0]   din_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [IDX_W-1:0]    rr_q;
    logic [SYNC_W-1:0]   sync_q;
    logic [SYNC_W-1:0]   sync_d;
    logic [SRC_W-1:0]    src_q;
    logic                is_data_q;

    logic                boundary_c;
    logic                load_c;
    logic                send_sync_c;
    logic                grant_c;
    logic                gnt_found;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    cand;
    logic [WORD_W-1:0]   gnt_data;

    assign boundary_c  = ((state_q == ST_IDLE) && lane_en) ||
                         ((state_q == ST_RUN) && (slot_q == LAST_SLOT));
    assign load_c      = boundary_c && lane_en;
    assign send_sync_c = (sync_q == '0);
    assign grant_c     = load_c && !send_sync_c && gnt_found && !reset;
    assign sync_d      = (sync_q == SYNC_W'(SYNC_INTERVAL - 1)) ? '0 : sync_q + SYNC_W'(1);

    // Round-robin search starting one past the last granted source.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                gnt_data = req_data[WORD_W*i +: WORD_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_c) begin
            req_ready = NUM_REQ'(1) << gnt_idx;
        end
    end

    // Lane FSM; ser_din only changes on boundary edges so the serializer loads a stable word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            din_q     <= IDLE_WORD;
            slot_q    <= '0;
            rr_q      <= IDX_W'(NUM_REQ - 1);
            sync_q    <= '0;
            src_q     <= '0;
            is_data_q <= 1'b0;
        end else begin
            if (state_q == ST_RUN) begin
                slot_q <= slot_q + SLOT_W'(1);
            end
            if (load_c) begin
                state_q <= ST_RUN;
                en_q    <= 1'b1;
                sync_q  <= sync_d;
                if (send_sync_c) begin
                    din_q     <= SYNC_WORD;
                    is_data_q <= 1'b0;
                end else if (gnt_found) begin
                    din_q     <= gnt_data;
                    rr_q      <= gnt_idx;
                    src_q     <= SRC_W'(gnt_idx);
                    is_data_q <= 1'b1;
                end else begin
                    din_q     <= IDLE_WORD;
                    is_data_q <= 1'b0;
                end
            end else if (boundary_c) begin
                // Stop only after the in-flight word has shifted its last bit.
                state_q   <= ST_IDLE;
                en_q      <= 1'b0;
                din_q     <= IDLE_WORD;
                slot_q    <= '0;
                sync_q    <= '0;
                is_data_q <= 1'b0;
            end
        end
    end

    assign ser_enable  = en_q;
    assign ser_din     = din_q;
    assign busy        = (state_q == ST_RUN);
    assign slot_cnt    = slot_q;
    assign cur_src     = src_q;
    assign cur_is_data = is_data_q;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Directed bench for serdes_tx_scheduler with a small serializer model that
// reconstructs each transmitted word from the serial stream.
module tb_serdes_tx_scheduler;

    localparam int unsigned NUM_REQ = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  lane_en;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  ser_enable;
    logic [15:0]           ser_din;
    logic                  busy;
    logic [3:0]            slot_cnt;
    logic [2:0]            cur_src;
    logic                  cur_is_data;

    int n_tests = 0;
    int n_fail  = 0;

    serdes_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .SYNC_INTERVAL(8),
        .IDLE_WORD    (16'h00FF),
        .SYNC_WORD    (16'hF0F0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .lane_en    (lane_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .ser_enable (ser_enable),
        .ser_din    (ser_din),
        .busy       (busy),
        .slot_cnt   (slot_cnt),
        .cur_src    (cur_src),
        .cur_is_data(cur_is_data)
    );

    always #5 clock = ~clock;

    // Serializer model: counts while enabled, loads on the falling edge at count 0, LSB first.
    logic [3:0]  sm_cnt   = 4'd0;
    logic [15:0] sm_reg   = 16'h0;
    logic [15:0] ser_hist = 16'h0;

    always @(posedge clock) begin
        sm_cnt   <= ser_enable ? sm_cnt + 4'd1 : 4'd0;
        ser_hist <= {sm_reg[sm_cnt], ser_hist[15:1]};
    end

    always @(negedge clock) begin
        if (sm_cnt == 4'd0) sm_reg <= ser_din;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        lane_en   = 1'b0;
        req_valid = '0;
        ticks(2);
        check("rst ser_enable", ser_enable, 0);
        check("rst ser_din", ser_din, 16'h00FF);
        check("rst slot_cnt", slot_cnt, 0);
        check("rst busy", busy, 0);
        check("rst cur_is_data", cur_is_data, 0);
        check("rst cur_src", cur_src, 0);
        check("rst req_ready", req_ready, 0);
        reset = 1'b0;
    endtask

    task automatic start();
        lane_en = 1'b1;
        check("start en before edge", ser_enable, 0);
        tick();
        check("start en after edge", ser_enable, 1);
        check("start busy", busy, 1);
        check("start din sync", ser_din, 16'hF0F0);
        check("start slot 0", slot_cnt, 0);
    endtask

    // Called at slot_cnt 0 of a slot; returns at slot_cnt 0 of the following slot.
    task automatic run_slot(input string tag, input logic [15:0] exp_din, input logic exp_data,
                            input logic [2:0] exp_src, input logic [3:0] exp_gnt);
        int bad = 0;
        check({tag, " din"}, ser_din, exp_din);
        check({tag, " is_data"}, cur_is_data, exp_data);
        if (exp_data) check({tag, " src"}, cur_src, exp_src);
        check({tag, " slot0"}, slot_cnt, 0);
        for (int c = 0; c < 15; c++) begin
            if (req_ready !== '0 || ser_din !== exp_din || ser_enable !== 1'b1) bad++;
            tick();
        end
        check({tag, " steady"}, bad, 0);
        check({tag, " slot15"}, slot_cnt, 15);
        check({tag, " ser count align"}, sm_cnt, 15);
        check({tag, " ready"}, req_ready, exp_gnt);
        tick();
        check({tag, " serial word"}, ser_hist, exp_din);
    endtask

    logic [15:0] t3_din  [10] = '{16'hF0F0, 16'hA000, 16'hA001, 16'hA002, 16'hA003,
                                  16'hA000, 16'hA001, 16'hA002, 16'hF0F0, 16'hA003};
    logic        t3_data [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [2:0]  t3_src  [10] = '{0, 0, 1, 2, 3, 0, 1, 2, 0, 3};
    logic [3:0]  t3_gnt  [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                  4'b0010, 4'b0100, 4'b0000, 4'b1000, 4'b0001};

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        lane_en   = 1'b0;
        req_valid = '0;
        req_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        tick();

        // Idle lane: SYNC, seven IDLE words, SYNC again.
        do_reset();
        start();
        for (int s = 0; s < 9; s++) begin
            run_slot($sformatf("idle s%0d", s), (s == 0 || s == 8) ? 16'hF0F0 : 16'h00FF,
                     1'b0, 3'd0, 4'b0000);
        end

        // Single source 2 granted at the end of the SYNC slot.
        do_reset();
        req_data  = {16'hA003, 16'h1234, 16'hA001, 16'hA000};
        req_valid = 4'b0100;
        start();
        run_slot("src2 s0", 16'hF0F0, 1'b0, 3'd0, 4'b0100);
        req_valid = '0;
        run_slot("src2 s1", 16'h1234, 1'b1, 3'd2, 4'b0000);

        // All sources valid: round-robin with SYNC interruption.
        do_reset();
        req_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        req_valid = 4'b1111;
        start();
        for (int s = 0; s < 10; s++) begin
            run_slot($sformatf("rr s%0d", s), t3_din[s], t3_data[s], t3_src[s], t3_gnt[s]);
        end

        // lane_en dropped mid-word, with a valid source at the stop boundary.
        do_reset();
        start();
        ticks(5);
        lane_en   = 1'b0;
        req_valid = 4'b0001;
        ticks(10);
        check("stop slot15", slot_cnt, 15);
        check("stop en held", ser_enable, 1);
        check("stop din held", ser_din, 16'hF0F0);
        check("stop no grant", req_ready, 0);
        tick();
        check("stop en", ser_enable, 0);
        check("stop din", ser_din, 16'h00FF);
        check("stop busy", busy, 0);
        check("stop slot", slot_cnt, 0);
        check("stop word finished", ser_hist, 16'hF0F0);
        ticks(3);
        check("stop slot held", slot_cnt, 0);
        req_valid = '0;
        start();

        // Reset mid-slot while source 1 waits for the boundary.
        do_reset();
        req_valid = 4'b0010;
        start();
        ticks(9);
        check("midrst slot9", slot_cnt, 9);
        check("midrst no ready", req_ready, 0);
        reset = 1'b1;
        tick();
        check("midrst en", ser_enable, 0);
        check("midrst din", ser_din, 16'h00FF);
        check("midrst slot", slot_cnt, 0);
        check("midrst busy", busy, 0);
        check("midrst ready forced", req_ready, 0);
        tick();
        check("midrst reset priority", busy, 0);
        reset = 1'b0;
        tick();
        check("midrst restart en", ser_enable, 1);
        check("midrst restart sync", ser_din, 16'hF0F0);
        run_slot("midrst s0", 16'hF0F0, 1'b0, 3'd0, 4'b0010);
        req_valid = '0;
        run_slot("midrst s1", 16'hA001, 1'b1, 3'd1, 4'b0000);

        // Source 0 valid only mid-slot: no grant at the boundary.
        do_reset();
        start();
        run_slot("drop s0", 16'hF0F0, 1'b0, 3'd0, 4'b0000);
        ticks(3);
        req_valid = 4'b0001;
        check("drop mid no ready", req_ready, 0);
        ticks(8);
        req_valid = '0;
        ticks(4);
        check("drop boundary slot", slot_cnt, 15);
        check("drop boundary no grant", req_ready, 0);
        tick();
        check("drop next idle", ser_din, 16'h00FF);
        check("drop next is_data", cur_is_data, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_tx_scheduler.md
# serdes_tx_scheduler

Transmit-side scheduler for the 16:1 serializer lane. It shares one serializer among NUM_REQ word sources using round-robin valid/ready arbitration. It drives the serializer's `enable` and `din` so that each new word is presented during the load slot, where the serializer's 4-bit count is 0. It inserts IDLE words when no source is ready and a SYNC word every SYNC_INTERVAL word slots.

## Interface
- NUM_REQ, 4: number of requesters, legal range 2..8.
- SYNC_INTERVAL, 8: word slots per sync period, legal range 2..256. One slot per period carries SYNC_WORD.
- IDLE_WORD, 16'h00FF: word sent when no requester is valid.
- SYNC_WORD, 16'hF0F0: alignment word.
- clock  in  1  single clock, rising edge; shared with the serializer.
- reset  in  1  synchronous, active-high.
- lane_en  in  1  request to run the lane; sampled only in boundary cycles.
- req_valid  in  NUM_REQ  per-source word valid.
- req_data  in  16*NUM_REQ  per-source word; source i occupies bits [16i+15:16i].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready are both high at a rising edge.
- ser_enable  out  1  registered; drives serializer `enable`.
- ser_din  out  16  registered; drives serializer `din`.
- busy  out  1  high in RUN.
- slot_cnt  out  4  registered slot counter; mirrors the serializer count.
- cur_src  out  3  source of the word in ser_din; valid when cur_is_data is high.
- cur_is_data  out  1  the word in ser_din came from a requester, not IDLE or SYNC.

## Operation
- Reset is synchronous and active-high. Reset values:
  - state = IDLE
  - ser_enable = 0
  - ser_din = IDLE_WORD
  - slot_cnt = 0
  - rr_ptr = NUM_REQ-1, so source 0 has first priority
  - sync_cnt = 0
  - cur_is_data = 0, cur_src = 0, busy = 0
  - req_ready = 0; this is combinational and forced to 0 while reset is high.
- States are IDLE and RUN.
- The boundary cycle is defined as (IDLE and lane_en) or (RUN and slot_cnt == 15). Arbitration and all state transitions happen only in boundary cycles.
- In IDLE:
  - ser_enable = 0, slot_cnt held at 0, ser_din = IDLE_WORD. The serializer repeatedly reloads IDLE_WORD.
  - If lane_en = 1 in this cycle, it is a boundary cycle; the next state is RUN and ser_enable <= 1.
- In RUN:
  - slot_cnt increments by 1 each cycle and wraps 15 -> 0.
  - In a boundary cycle with lane_en = 0: the next state is IDLE, ser_enable <= 0, ser_din <= IDLE_WORD, slot_cnt <= 0, and no grant is issued.
  - The word already in flight always completes all 16 bits before the lane stops.
- Word selection in a RUN-bound boundary cycle, in priority order:
  1. If sync_cnt == 0, send SYNC_WORD. No grant is issued and rr_ptr is unchanged.
  2. Otherwise, if any req_valid is high, grant the first valid source searching upward from rr_ptr+1, modulo NUM_REQ. Assert req_ready for that source in this cycle only. At the edge, ser_din <= that source's data, rr_ptr <= granted index, cur_src <= index, cur_is_data <= 1.
  3. Otherwise, send IDLE_WORD with cur_is_data <= 0.
- sync_cnt update: at each RUN-bound boundary edge, sync_cnt <= (sync_cnt == SYNC_INTERVAL-1) ? 0 : sync_cnt+1. On entry to IDLE, sync_cnt resets to 0, so the first word after every start is SYNC.
- req_ready is zero outside boundary cycles, in stop cycles, and in SYNC cycles. A requester must hold req_valid and req_data stable until it is granted; dropping valid before grant is legal and loses nothing.
- req_valid is sampled combinationally only in boundary cycles.

## Timing
- Start sequence:
  - Edge E0 is the IDLE -> RUN edge. After E0: ser_enable = 1, slot_cnt = 0, ser_din = SYNC_WORD.
  - The serializer count is still 0 after E0, because it sampled enable = 0 at E0. It loads SYNC_WORD on the following falling edge.
  - At E1, both the serializer count and slot_cnt become 1 and stay aligned from then on.
- Each word occupies exactly 16 cycles. ser_din changes only at boundary edges, so it is stable through the falling edge where the serializer loads.
- Grant-to-wire latency: source data granted in boundary cycle B appears on ser_din after edge B. Its bit 0 appears on the serial output during the next cycle. Bit k follows k cycles later, LSB first.
- Back-to-back grants to the same source are 16 cycles apart. With all NUM_REQ sources valid, each source is granted once per NUM_REQ data slots.
- Reset mid-word:
  - The controller returns to the reset state at that edge and the word in flight is truncated.
  - No handshake is lost, because grants occur only in boundary cycles.
  - Reset has priority over lane_en.
- Simultaneous lane_en deassertion and req_valid in a RUN boundary cycle: the lane stops and no grant is issued.

## Test plan
- Reset, then lane_en = 1 with no valid sources:
  - ser_din sequence is F0F0, then 00FF ×7, then F0F0, each for 16 cycles.
  - ser_enable rises one edge after lane_en is sampled, and req_ready stays 0.
- Source 2 valid with data 16'h1234 from start:
  - Slot 0 is SYNC.
  - req_ready[2] pulses for one cycle at slot_cnt = 15 of slot 0.
  - Serial output carries 0,0,1,0,1,1,0,0,... (LSB first) in slot 1.
- All 4 sources held valid:
  - Grant order is 0,1,2,3,0,1,2 across slots 1..7.
  - Slot 8 is SYNC with no grant; slot 9 grants source 3.
- lane_en dropped at slot_cnt = 5:
  - The current word finishes through slot_cnt = 15, then ser_enable = 0 and ser_din = 00FF.
  - A later restart begins with SYNC.
- Reset asserted at slot_cnt = 9 while source 1 is valid:
  - All outputs take reset values at the next edge, and req_ready[1] never pulses.
  - After restart, source 1 is granted in slot 1.
- Source 0 valid only for cycles 3..10 of a slot, dropping before the boundary:
  - No grant is issued, and the next slot is 00FF.
